// File: rtl/mux83_arb_pkg.sv
// Shared types and constants for the round-robin arbiter around mux83.
package mux83_arb_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Turn a requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux83_arbiter_if.sv
// Request/data/handshake bundle between the requesters, the arbiter and the consumer.
interface mux83_arbiter_if;
    import mux83_arb_pkg::*;

    logic [N_REQ-1:0]  req;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] din_b;
    logic [DATA_W-1:0] din_c;
    logic [DATA_W-1:0] din_d;
    logic [DATA_W-1:0] din_e;
    logic [DATA_W-1:0] din_f;
    logic [DATA_W-1:0] din_g;
    logic [DATA_W-1:0] din_h;
    logic              ack;
    logic [N_REQ-1:0]  grant;
    logic [SEL_W-1:0]  sel;
    logic              valid;
    logic [DATA_W-1:0] dout;
    logic              timeout;

    // Environment side: requesters and downstream consumer.
    modport master (
        output req, din_a, din_b, din_c, din_d, din_e, din_f, din_g, din_h, ack,
        input  grant, sel, valid, dout, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, din_a, din_b, din_c, din_d, din_e, din_f, din_g, din_h, ack,
        output grant, sel, valid, dout, timeout
    );

endinterface

// File: rtl/mux83.sv
// 8-input, 8-bit selection mux shared by the requesters.
module mux83
    import mux83_arb_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] h,
    output logic [DATA_W-1:0] y
);

    // Route the selected input straight through.
    always_comb begin
        case (sel)
            3'd0:    y = a;
            3'd1:    y = b;
            3'd2:    y = c;
            3'd3:    y = d;
            3'd4:    y = e;
            3'd5:    y = f;
            3'd6:    y = g;
            default: y = h;
        endcase
    end

endmodule

// File: rtl/mux83_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after 'last', wrapping modulo 8.
module rr_pick
    import mux83_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    // Walk the offsets from farthest to nearest so the nearest hit after 'last' wins;
    // offset 8 wraps back to 'last' itself, giving it the lowest priority.
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        onehot = any ? idx_to_onehot(idx) : '0;
    end

endmodule

// File: rtl/mux83_arbiter.sv
// Round-robin arbiter driving mux83's select, with valid/ack handshake and a grant watchdog.
module mux83_arbiter
    import mux83_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mux83_arbiter_if.slave  bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t       state_q, state_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [SEL_W-1:0] last_q, last_n;
    logic             valid_q, valid_n;
    logic             timeout_q, timeout_n;
    logic [7:0]       cnt_q, cnt_n;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [SEL_W-1:0] pick_last;

    // On completion the served requester becomes 'last' on the same edge,
    // so the picker scans from the current sel while a grant is active.
    assign pick_last = (state_q == GRANT) ? sel_q : last_q;

    rr_pick u_pick (
        .req    (bus.req),
        .last   (pick_last),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    mux83 u_mux (
        .sel (sel_q),
        .a   (bus.din_a),
        .b   (bus.din_b),
        .c   (bus.din_c),
        .d   (bus.din_d),
        .e   (bus.din_e),
        .f   (bus.din_f),
        .g   (bus.din_g),
        .h   (bus.din_h),
        .y   (bus.dout)
    );

    // State and registered outputs; reset puts requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= 3'd7;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            sel_q     <= sel_n;
            last_q    <= last_n;
            valid_q   <= valid_n;
            timeout_q <= timeout_n;
            cnt_q     <= cnt_n;
        end
    end

    // Arbitration, completion and watchdog decisions; ack takes precedence over expiry.
    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        sel_n     = sel_q;
        last_n    = last_q;
        valid_n   = valid_q;
        timeout_n = 1'b0;
        cnt_n     = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    grant_n = pick_onehot;
                    sel_n   = pick_idx;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    last_n = sel_q;
                    cnt_n  = '0;
                    if (pick_any) begin
                        grant_n = pick_onehot;
                        sel_n   = pick_idx;
                        valid_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end else if (cnt_q == TO_LAST) begin
                    last_n    = sel_q;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                    grant_n   = '0;
                    valid_n   = 1'b0;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    // Present the registered state on the bus.
    always_comb begin
        bus.grant   = grant_q;
        bus.sel     = sel_q;
        bus.valid   = valid_q;
        bus.timeout = timeout_q;
    end

endmodule

// File: tb/tb_mux83_arbiter.sv
// Directed and randomized checks of mux83_arbiter against a transaction-level model.
module tb_mux83_arbiter;

    localparam int TO = 16;

    logic clk;
    logic rst_n;

    mux83_arbiter_if bus ();

    mux83_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int din_v [8] = '{7, 5, 3, 2, 5, 3, 6, 1};
    int rr_dout [9] = '{7, 5, 3, 2, 5, 3, 6, 1, 7};

    // Model: who holds the mux, who was served last, edges elapsed since the grant.
    bit m_busy;
    int m_idx;
    int m_last;
    int m_wait;
    bit m_to;
    bit m_fresh;
    int to_seen;

    function automatic int rrNext(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_busy  = 0;
        m_idx   = 0;
        m_last  = 7;
        m_wait  = 0;
        m_to    = 0;
        m_fresh = 1;
    endtask

    task automatic modelEdge(input logic [7:0] r, input logic a);
        m_to = 0;
        if (!m_busy) begin
            if (r != 0) begin
                m_idx   = rrNext(r, m_last);
                m_busy  = 1;
                m_wait  = 0;
                m_fresh = 0;
            end
        end else if (a) begin
            m_last = m_idx;
            if (r != 0) begin
                m_idx  = rrNext(r, m_last);
                m_wait = 0;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_wait++;
            if (m_wait == TO) begin
                m_last = m_idx;
                m_busy = 0;
                m_to   = 1;
            end
        end
    endtask

    task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp_grant;
        exp_grant = m_busy ? 8'(1 << m_idx) : 8'h00;
        compare({tag, ".grant"}, 32'(bus.grant), 32'(exp_grant));
        compare({tag, ".valid"}, 32'(bus.valid), 32'(m_busy));
        compare({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
        if (m_busy) begin
            compare({tag, ".sel"}, 32'(bus.sel), 32'(m_idx));
            compare({tag, ".dout"}, 32'(bus.dout), 32'(din_v[m_idx]));
        end else if (m_fresh) begin
            compare({tag, ".sel_rst"}, 32'(bus.sel), 32'd0);
        end
        if (bus.timeout === 1'b1) to_seen++;
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic a, input string tag);
        @(negedge clk);
        bus.req = r;
        bus.ack = a;
        @(posedge clk);
        modelEdge(r, a);
        #1;
        checkOutput(tag);
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, ".async"});
        @(posedge clk);
        #1;
        checkOutput({tag, ".held"});
        @(negedge clk);
        bus.req = '0;
        bus.ack = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [7:0] r;
        logic       a;
        int         ack_pct;

        rst_n     = 1'b0;
        bus.req   = '0;
        bus.ack   = 1'b0;
        bus.din_a = 8'(din_v[0]);
        bus.din_b = 8'(din_v[1]);
        bus.din_c = 8'(din_v[2]);
        bus.din_d = 8'(din_v[3]);
        bus.din_e = 8'(din_v[4]);
        bus.din_f = 8'(din_v[5]);
        bus.din_g = 8'(din_v[6]);
        bus.din_h = 8'(din_v[7]);
        modelReset();
        to_seen = 0;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h00, 1'b0, "idle0");
        applyStimulus(8'h00, 1'b1, "idle_ack");

        $display("[TB] single request");
        applyStimulus(8'b0000_1000, 1'b0, "single.g");
        compare("single.sel3", 32'(bus.sel), 32'd3);
        compare("single.dout2", 32'(bus.dout), 32'd2);
        applyStimulus(8'b0000_1000, 1'b0, "single.w1");
        applyStimulus(8'b0000_1000, 1'b0, "single.w2");
        applyStimulus(8'b0000_0000, 1'b1, "single.ack");
        compare("single.idle", 32'(bus.valid), 32'd0);

        $display("[TB] round robin");
        applyReset("rr_rst");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'hFF, 1'b1, "rr");
            compare("rr.sel_seq", 32'(bus.sel), 32'(i % 8));
            compare("rr.dout_seq", 32'(bus.dout), 32'(rr_dout[i]));
        end
        applyStimulus(8'h00, 1'b1, "rr.drain");

        $display("[TB] timeout");
        applyReset("to_rst");
        to_seen = 0;
        applyStimulus(8'b0000_0101, 1'b0, "to.g");
        for (int i = 1; i < TO; i++) applyStimulus(8'b0000_0101, 1'b0, "to.wait");
        compare("to.still_sel0", 32'(bus.sel), 32'd0);
        applyStimulus(8'b0000_0101, 1'b0, "to.fire");
        compare("to.pulse", 32'(bus.timeout), 32'd1);
        applyStimulus(8'b0000_0101, 1'b0, "to.regrant");
        compare("to.next_sel2", 32'(bus.sel), 32'd2);
        compare("to.next_dout3", 32'(bus.dout), 32'd3);
        compare("to.one_pulse", 32'(to_seen), 32'd1);
        applyStimulus(8'h00, 1'b1, "to.drain");

        $display("[TB] ack/timeout collision");
        applyReset("col_rst");
        to_seen = 0;
        applyStimulus(8'b0001_0000, 1'b0, "col.g");
        for (int i = 1; i < TO; i++) applyStimulus(8'h00, 1'b0, "col.wait");
        applyStimulus(8'h00, 1'b1, "col.ack");
        applyStimulus(8'h00, 1'b0, "col.after");
        compare("col.no_pulse", 32'(to_seen), 32'd0);

        $display("[TB] reset mid-grant");
        applyStimulus(8'b0100_0000, 1'b0, "mid.g");
        applyStimulus(8'b0100_0000, 1'b0, "mid.w");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compare("mid.grant0", 32'(bus.grant), 32'd0);
        compare("mid.valid0", 32'(bus.valid), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] random");
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 8'h00;
                1:       r = 8'($urandom) & 8'($urandom) & 8'($urandom);
                default: r = 8'($urandom);
            endcase
            ack_pct = ((i / 200) % 2 == 0) ? 60 : 8;
            a = ($urandom_range(0, 99) < ack_pct) ? 1'b1 : 1'b0;
            applyStimulus(r, a, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
